// File: rtl/rv32i_mem_pkg.sv
// Shared types for the rv32i memory arbiter slice.
//   mem_mode_t  : RAM access mode, encodings match the existing mem defines.
//   arb_state_t : arbiter FSM states.
//   owner_t     : which requester owns the in-flight transaction.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    MEM_READ       = 2'd0,
    MEM_WRITE_WORD = 2'd1,
    MEM_WRITE_HALF = 2'd2,
    MEM_WRITE_BYTE = 2'd3
  } mem_mode_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/rv32i_mem_arb_pick.sv
// Combinational grant selection for the rv32i memory arbiter.
//   en         : arbiter is in IDLE and may grant this cycle
//   if_valid   : fetch request pending
//   d_valid    : data request pending
//   last_owner : requester granted last (only with RV32I_MEM_ARB_RR_EN)
//   grant      : one-hot grant, [0]=IF, [1]=D; all-zero when nothing granted
// Macro RV32I_MEM_ARB_RR_EN selects round-robin on contention; otherwise D
// always wins over IF.
module rv32i_mem_arb_pick
  import rv32i_mem_pkg::*;
(
  input  logic       en,
  input  logic       if_valid,
  input  logic       d_valid,
`ifdef RV32I_MEM_ARB_RR_EN
  input  owner_t     last_owner,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (en) begin
      if (if_valid && d_valid) begin
`ifdef RV32I_MEM_ARB_RR_EN
        grant = (last_owner == OWN_D) ? 2'b01 : 2'b10;
`else
        grant = 2'b10;
`endif
      end else begin
        grant = {d_valid, if_valid};
      end
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing the single-port rv32i byte RAM between instruction fetch
// (read-only) and the data load/store unit.
//   clk, rst              : clock, asynchronous active-low reset
//   if_req_* / if_rsp_*   : fetch request (valid/ready/addr) and response
//   d_req_* / d_rsp_*     : data request (valid/ready/mode/addr/wdata) and
//                           response (load data, 0 for stores)
//   ram_rst, ram_mode,
//   ram_address,
//   ram_write_value       : registered RAM controls
//   ram_value             : RAM registered read value
//   busy                  : FSM is not in IDLE
// One transaction at a time: IDLE (grant) -> ISSUE (RAM samples) -> RESP
// (one-cycle response pulse). After reset ram_rst is held for INIT_CYCLES.
// Macro RV32I_MEM_ARB_RR_EN enables round-robin arbitration on contention.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int INIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [1:0]            d_req_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_data,
  output logic                  ram_rst,
  output logic [1:0]            ram_mode,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_value,
  input  logic [31:0]           ram_value,
  output logic                  busy
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  arb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                  ram_rst_q, ram_rst_d;
  mem_mode_t             ram_mode_q, ram_mode_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  owner_t                owner_q, owner_d;
  logic                  is_read_q, is_read_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           d_data_q, d_data_d;
`ifdef RV32I_MEM_ARB_RR_EN
  owner_t                last_q, last_d;
`endif

  logic       in_idle;
  logic [1:0] grant;

  assign in_idle = (state_q == IDLE);

  rv32i_mem_arb_pick u_pick (
    .en         (in_idle),
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
`ifdef RV32I_MEM_ARB_RR_EN
    .last_owner (last_q),
`endif
    .grant      (grant)
  );

  assign if_req_ready    = grant[0];
  assign d_req_ready     = grant[1];
  assign busy            = !in_idle;
  assign ram_rst         = ram_rst_q;
  assign ram_mode        = ram_mode_q;
  assign ram_address     = ram_addr_q;
  assign ram_write_value = ram_wdata_q;

  // Response data is live from the RAM during the pulse and held afterwards,
  // so the non-owning port's data never changes.
  assign if_rsp_valid = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_rsp_valid  = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rsp_data  = if_rsp_valid ? ram_value : if_data_q;
  assign d_rsp_data   = d_rsp_valid ? (is_read_q ? ram_value : '0) : d_data_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ram_rst_d   = ram_rst_q;
    ram_mode_d  = ram_mode_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    owner_d     = owner_q;
    is_read_d   = is_read_q;
    if_data_d   = if_rsp_data;
    d_data_d    = d_rsp_data;
`ifdef RV32I_MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      INIT: begin
        ram_rst_d = 1'b1;
        if (init_cnt_q == CNT_LAST) begin
          init_cnt_d = '0;
          ram_rst_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (grant[1]) begin
          owner_d     = OWN_D;
          ram_mode_d  = mem_mode_t'(d_req_mode);
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
          is_read_d   = (mem_mode_t'(d_req_mode) == MEM_READ);
          state_d     = ISSUE;
        end else if (grant[0]) begin
          owner_d     = OWN_IF;
          ram_mode_d  = MEM_READ;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
          is_read_d   = 1'b1;
          state_d     = ISSUE;
        end
`ifdef RV32I_MEM_ARB_RR_EN
        if (grant != 2'b00) begin
          last_d = grant[1] ? OWN_D : OWN_IF;
        end
`endif
      end
      ISSUE: begin
        // RAM has committed the access at this edge; park it on a read.
        ram_mode_d  = MEM_READ;
        ram_wdata_d = '0;
        state_d     = RESP;
      end
      RESP: begin
        ram_addr_d = '0;
        state_d    = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      ram_rst_q   <= 1'b1;
      ram_mode_q  <= MEM_READ;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      owner_q     <= OWN_IF;
      is_read_q   <= 1'b1;
      if_data_q   <= '0;
      d_data_q    <= '0;
`ifdef RV32I_MEM_ARB_RR_EN
      last_q      <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ram_rst_q   <= ram_rst_d;
      ram_mode_q  <= ram_mode_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      owner_q     <= owner_d;
      is_read_q   <= is_read_d;
      if_data_q   <= if_data_d;
      d_data_q    <= d_data_d;
`ifdef RV32I_MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [4:0]  if_addr;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid;
  logic [1:0]  d_req_mode;
  logic [4:0]  d_addr;
  logic [31:0] d_wdata, d_rsp_data;
  logic        ram_rst;
  logic [1:0]  ram_mode;
  logic [4:0]  ram_address;
  logic [31:0] ram_write_value, ram_value;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.ADDR_WIDTH(5), .INIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_mode(d_req_mode),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_rst(ram_rst), .ram_mode(ram_mode), .ram_address(ram_address),
    .ram_write_value(ram_write_value), .ram_value(ram_value), .busy(busy)
  );

  // Byte RAM model: byte[a] lands in [31:24] of a read, writes are LSB first.
  logic [7:0] mem [0:31];
  logic [4:0] a1, a2, a3;
  logic       preload_en = 1'b0;
  logic [4:0] preload_addr;
  logic [7:0] preload_byte;
  assign a1 = ram_address + 5'd1;
  assign a2 = ram_address + 5'd2;
  assign a3 = ram_address + 5'd3;

  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      ram_value <= '0;
    end else begin
      case (ram_mode)
        2'd0: ram_value <= {mem[ram_address], mem[a1], mem[a2], mem[a3]};
        2'd1: begin
          mem[ram_address] <= ram_write_value[7:0];
          mem[a1] <= ram_write_value[15:8];
          mem[a2] <= ram_write_value[23:16];
          mem[a3] <= ram_write_value[31:24];
          ram_value <= 32'hFFFF_FFFF;
        end
        2'd2: begin
          mem[ram_address] <= ram_write_value[7:0];
          mem[a1] <= ram_write_value[15:8];
          ram_value <= 32'hFFFF_FFFF;
        end
        default: begin
          mem[ram_address] <= ram_write_value[7:0];
          ram_value <= 32'hFFFF_FFFF;
        end
      endcase
      if (preload_en) mem[preload_addr] <= preload_byte;
    end
  end

  task automatic preload(input logic [4:0] a, input logic [7:0] b);
    preload_addr = a; preload_byte = b; preload_en = 1'b1;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  // Drives one request; starts and ends 1 time unit after a rising edge.
  // acc: cycles waited for ready (-1 = never); lat: cycles from accept to
  // own response pulse (-1 = none); wrong: other-port or duplicate pulses.
  task automatic run_req(input bit is_d, input logic [1:0] mode, input logic [4:0] addr,
                         input logic [31:0] wdata, output int acc, output int lat,
                         output logic [31:0] data, output int wrong);
    bit own, other;
    acc = -1; lat = -1; data = '0; wrong = 0;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_mode = mode; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if ((is_d ? d_req_ready : if_req_ready) === 1'b1) acc = k;
      @(posedge clk); #1;
    end
    d_req_valid = 1'b0; if_req_valid = 1'b0;
    if (acc >= 0) begin
      for (int n = 1; n <= 6; n++) begin
        @(negedge clk);
        own   = is_d ? d_rsp_valid : if_rsp_valid;
        other = is_d ? if_rsp_valid : d_rsp_valid;
        if (other) wrong++;
        if (own) begin
          if (lat < 0) begin
            lat = n; data = is_d ? d_rsp_data : if_rsp_data;
          end else wrong++;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ram_rst, busy} !== 2'b11) begin
      bad++; $display("FAIL reset_rst_busy got=%b exp=11", {ram_rst, busy});
    end
    total++;
    if ({ram_mode, ram_address, ram_write_value} !== 39'd0) begin
      bad++; $display("FAIL reset_ram_regs got=%h/%h/%h exp=0/0/0", ram_mode, ram_address, ram_write_value);
    end
    total++;
    if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid} !== 4'b0000 ||
        if_rsp_data !== 32'd0 || d_rsp_data !== 32'd0) begin
      bad++; $display("FAIL reset_outputs got=%b %h %h exp=0000 0 0",
        {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid}, if_rsp_data, d_rsp_data);
    end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if ({ram_rst, busy} !== 2'b11) begin
      bad++; $display("FAIL init_cycle got=%b exp=11", {ram_rst, busy});
    end
    @(negedge clk);
    total++;
    if ({ram_rst, busy, if_req_ready, d_req_ready} !== 4'b0000) begin
      bad++; $display("FAIL idle_after_init got=%b exp=0000", {ram_rst, busy, if_req_ready, d_req_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int acc, lat, wrong;
    logic [31:0] data;
    preload(5'd0, 8'h13); preload(5'd1, 8'h00); preload(5'd2, 8'h00); preload(5'd3, 8'h00);
    run_req(1'b0, 2'd0, 5'd0, 32'd0, acc, lat, data, wrong);
    total++;
    if (acc !== 0 || lat !== 2 || wrong !== 0) begin
      bad++; $display("FAIL fetch_timing got acc=%0d lat=%0d wrong=%0d exp 0/2/0", acc, lat, wrong);
    end
    total++;
    if (data !== 32'h1300_0000) begin
      bad++; $display("FAIL fetch_data got=%h exp=13000000", data);
    end
    total++;
    if (if_rsp_data !== 32'h1300_0000 || if_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_hold got=%h/%b exp=13000000/0", if_rsp_data, if_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    int acc, lat, wrong;
    logic [31:0] data;
    run_req(1'b1, 2'd2, 5'd4, 32'hAABB_CCDD, acc, lat, data, wrong);
    total++;
    if (acc !== 0 || lat !== 2 || wrong !== 0 || data !== 32'd0) begin
      bad++; $display("FAIL store_half got acc=%0d lat=%0d wrong=%0d data=%h exp 0/2/0/0", acc, lat, wrong, data);
    end
    run_req(1'b1, 2'd0, 5'd4, 32'd0, acc, lat, data, wrong);
    total++;
    if (lat !== 2 || wrong !== 0 || data !== 32'hDDCC_0000) begin
      bad++; $display("FAIL load_half got lat=%0d wrong=%0d data=%h exp 2/0/ddcc0000", lat, wrong, data);
    end
    total++;
    if (if_rsp_data !== 32'h1300_0000) begin
      bad++; $display("FAIL if_data_unchanged got=%h exp=13000000", if_rsp_data);
    end
  endtask

  task automatic test_wrap();
    int acc, lat, wrong;
    logic [31:0] data;
    run_req(1'b1, 2'd1, 5'd30, 32'h1122_3344, acc, lat, data, wrong);
    total++;
    if ({mem[30], mem[31], mem[0], mem[1]} !== 32'h4433_2211) begin
      bad++; $display("FAIL wrap_bytes got=%h exp=44332211", {mem[30], mem[31], mem[0], mem[1]});
    end
    run_req(1'b1, 2'd0, 5'd30, 32'd0, acc, lat, data, wrong);
    total++;
    if (lat !== 2 || data !== 32'h4433_2211) begin
      bad++; $display("FAIL wrap_read got lat=%0d data=%h exp 2/44332211", lat, data);
    end
  endtask

  task automatic test_contention();
    int if_cnt = 0, d_cnt = 0, g = 0, cyc = 0, rsp_cyc = -10;
    bit gseq [8];
    bit rsp_own = 1'b0, ir, dr, exp_if, exp_d, exp_g;
    if_addr = 5'd0; d_addr = 5'd4; d_req_mode = 2'd0;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    while ((g < 8 || cyc <= rsp_cyc) && cyc < 60) begin
      @(negedge clk);
      ir = if_req_ready; dr = d_req_ready;
      exp_if = (cyc == rsp_cyc) && !rsp_own;
      exp_d  = (cyc == rsp_cyc) && rsp_own;
      total++;
      if (if_rsp_valid !== exp_if || d_rsp_valid !== exp_d || (ir && dr)) begin
        bad++; $display("FAIL contention_cycle%0d got rsp=%b%b rdy=%b%b exp rsp=%b%b one ready",
          cyc, if_rsp_valid, d_rsp_valid, ir, dr, exp_if, exp_d);
      end
      if ((ir || dr) && g < 8) begin
        gseq[g] = dr; g++; rsp_cyc = cyc + 2; rsp_own = dr;
      end
      @(posedge clk); #1;
      if (ir) begin if_cnt++; if_req_valid = (if_cnt < 4); end
      if (dr) begin d_cnt++; d_req_valid = (d_cnt < 4); end
      cyc++;
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    total++;
    if (g !== 8) begin
      bad++; $display("FAIL contention_grants got=%0d exp=8", g);
    end
    for (int i = 0; i < g; i++) begin
`ifdef RV32I_MEM_ARB_RR_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = (i < 4);
`endif
      total++;
      if (gseq[i] !== exp_g) begin
        bad++; $display("FAIL contention_order%0d got_d=%b exp_d=%b", i, gseq[i], exp_g);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int acc, lat, wrong;
    logic [31:0] data;
    run_req(1'b1, 2'd1, 5'd8, 32'hCAFE_BABE, acc, lat, data, wrong);
    d_req_valid = 1'b1; d_req_mode = 2'd0; d_addr = 5'd8;
    @(negedge clk);
    total++;
    if (d_req_ready !== 1'b1) begin
      bad++; $display("FAIL midop_accept got=%b exp=1", d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    total++;
    if ({busy, ram_rst, d_rsp_valid, if_rsp_valid} !== 4'b1100) begin
      bad++; $display("FAIL midop_reset got=%b exp=1100", {busy, ram_rst, d_rsp_valid, if_rsp_valid});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({d_rsp_valid, if_rsp_valid} !== 2'b00) begin
        bad++; $display("FAIL midop_no_rsp%0d got=%b exp=00", i, {d_rsp_valid, if_rsp_valid});
      end
    end
    rst = 1'b1; #1;
    total++;
    if ({ram_rst, busy} !== 2'b11) begin
      bad++; $display("FAIL midop_init got=%b exp=11", {ram_rst, busy});
    end
    @(negedge clk);
    total++;
    if ({ram_rst, busy, d_rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL midop_idle got=%b exp=000", {ram_rst, busy, d_rsp_valid});
    end
    @(posedge clk); #1;
    run_req(1'b1, 2'd0, 5'd8, 32'd0, acc, lat, data, wrong);
    total++;
    if (lat !== 2 || data !== 32'd0) begin
      bad++; $display("FAIL midop_cleared got lat=%0d data=%h exp 2/0", lat, data);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_req_mode = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_wrap();
    test_contention();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
